axi_read_arbiter: RTL and testbench

Two-master, one-slave AXI read-channel arbiter that shares a single slave read port between the instruction-fetch master (M0) and the data master (M1). Each grant covers exactly one read burst. The arbiter registers the winning AR request, forwards it to the slave with a master-index-extended ID, steers the R beats back to the owner, and releases the port on the final beat. A beat counter checks RLAST against ARLEN and flags mismatches.

---
 rtl/axi_read_arbiter.sv | 175 +++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Two-master, one-slave AXI read-channel arbiter with one burst per grant.
// The winner's AR payload is registered and sent to the slave with the master index prepended to the ID.
// R beats are steered back to the owner combinationally.
// A beat counter flags RLAST positions that disagree with ARLEN.
module axi_read_arbiter #(
   parameter int unsigned ID_W   = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   // master 0 (instruction fetch)
   input  logic [ID_W-1:0]     ARID_M0,
   input  logic [ADDR_W-1:0]   ARADDR_M0,
   input  logic [LEN_W-1:0]    ARLEN_M0,
   input  logic [2:0]          ARSIZE_M0,
   input  logic [1:0]          ARBURST_M0,
   input  logic                ARVALID_M0,
   output logic                ARREADY_M0,
   output logic [ID_W-1:0]     RID_M0,
   output logic [DATA_W-1:0]   RDATA_M0,
   output logic [1:0]          RRESP_M0,
   output logic                RLAST_M0,
   output logic                RVALID_M0,
   input  logic                RREADY_M0,
   // master 1 (data)
   input  logic [ID_W-1:0]     ARID_M1,
   input  logic [ADDR_W-1:0]   ARADDR_M1,
   input  logic [LEN_W-1:0]    ARLEN_M1,
   input  logic [2:0]          ARSIZE_M1,
   input  logic [1:0]          ARBURST_M1,
   input  logic                ARVALID_M1,
   output logic                ARREADY_M1,
   output logic [ID_W-1:0]     RID_M1,
   output logic [DATA_W-1:0]   RDATA_M1,
   output logic [1:0]          RRESP_M1,
   output logic                RLAST_M1,
   output logic                RVALID_M1,
   input  logic                RREADY_M1,
   // slave
   output logic [ID_W:0]       ARID_S,
   output logic [ADDR_W-1:0]   ARADDR_S,
   output logic [LEN_W-1:0]    ARLEN_S,
   output logic [2:0]          ARSIZE_S,
   output logic [1:0]          ARBURST_S,
   output logic                ARVALID_S,
   input  logic                ARREADY_S,
   input  logic [ID_W:0]       RID_S,
   input  logic [DATA_W-1:0]   RDATA_S,
   input  logic [1:0]          RRESP_S,
   input  logic                RLAST_S,
   input  logic                RVALID_S,
   output logic                RREADY_S,
   // status
   output logic                len_err,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t              state_q, state_d;
   logic                grant_q, prio_q;
   logic [ID_W-1:0]     arid_q;
   logic [ADDR_W-1:0]   araddr_q;
   logic [LEN_W-1:0]    arlen_q;
   logic [2:0]          arsize_q;
   logic [1:0]          arburst_q;
   logic [LEN_W-1:0]    cnt_q;
   logic                len_err_q;

   logic                take;
   logic                gnt_sel;
   logic                in_data;
   logic                beat;
   logic                len_err_d;
   logic                unused_rid_msb;

   // Only one burst is outstanding, so the returned grant bit carries no information.
   assign unused_rid_msb = RID_S[ID_W];

   assign in_data  = (state_q == DATA);
   assign RREADY_S = in_data & (grant_q ? RREADY_M1 : RREADY_M0);
   assign beat     = in_data & RVALID_S & RREADY_S;

   // Length check: RLAST must land exactly on beat index ARLEN.
   assign len_err_d = beat & (RLAST_S ? (cnt_q != arlen_q) : (cnt_q == arlen_q));

   // Next-state and grant selection.
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      gnt_sel = grant_q;
      unique case (state_q)
         IDLE: begin
            if (!rst && (ARVALID_M0 || ARVALID_M1)) begin
               take    = 1'b1;
               gnt_sel = (ARVALID_M0 && ARVALID_M1) ? prio_q : ARVALID_M1;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (ARREADY_S) state_d = DATA;
         end
         DATA: begin
            if (beat && RLAST_S) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Grant, round-robin priority, latched AR payload, beat counter and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q   <= 1'b0;
         prio_q    <= 1'b0;
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
         cnt_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         len_err_q <= len_err_d;
         if (take) begin
            grant_q   <= gnt_sel;
            arid_q    <= gnt_sel ? ARID_M1    : ARID_M0;
            araddr_q  <= gnt_sel ? ARADDR_M1  : ARADDR_M0;
            arlen_q   <= gnt_sel ? ARLEN_M1   : ARLEN_M0;
            arsize_q  <= gnt_sel ? ARSIZE_M1  : ARSIZE_M0;
            arburst_q <= gnt_sel ? ARBURST_M1 : ARBURST_M0;
            cnt_q     <= '0;
         end
         if (beat) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (RLAST_S) prio_q <= ~grant_q;
         end
      end
   end

   // AR accept is combinational and limited to the winner of this cycle.
   assign ARREADY_M0 = take & ~gnt_sel;
   assign ARREADY_M1 = take &  gnt_sel;

   // Slave AR channel from the latched payload.
   assign ARVALID_S = (state_q == ADDR);
   assign ARID_S    = {grant_q, arid_q};
   assign ARADDR_S  = araddr_q;
   assign ARLEN_S   = arlen_q;
   assign ARSIZE_S  = arsize_q;
   assign ARBURST_S = arburst_q;

   // R steering; payload is shared, only RVALID selects the owner.
   assign RVALID_M0 = in_data & ~grant_q & RVALID_S;
   assign RVALID_M1 = in_data &  grant_q & RVALID_S;
   assign RID_M0    = in_data ? RID_S[ID_W-1:0] : '0;
   assign RID_M1    = in_data ? RID_S[ID_W-1:0] : '0;
   assign RDATA_M0  = in_data ? RDATA_S : '0;
   assign RDATA_M1  = in_data ? RDATA_S : '0;
   assign RRESP_M0  = in_data ? RRESP_S : '0;
   assign RRESP_M1  = in_data ? RRESP_S : '0;
   assign RLAST_M0  = in_data & RLAST_S;
   assign RLAST_M1  = in_data & RLAST_S;

   assign len_err = len_err_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: directed requests and slave responses.
`timescale 1ns/1ps
module tb_axi_read_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1, RID_M0, RID_M1, ARLEN_S;
   logic [31:0] ARADDR_M0, ARADDR_M1, RDATA_M0, RDATA_M1, ARADDR_S, RDATA_S;
   logic [2:0]  ARSIZE_M0, ARSIZE_M1, ARSIZE_S;
   logic [1:0]  ARBURST_M0, ARBURST_M1, ARBURST_S, RRESP_M0, RRESP_M1, RRESP_S;
   logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
   logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
   logic [4:0]  ARID_S, RID_S;
   logic        ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S, len_err, busy;

   axi_read_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
      .clk(clk), .rst(rst),
      .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
      .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
      .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
      .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
      .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
      .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
      .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
      .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
      .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
      .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
      .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
      .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
      .len_err(len_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_t;

   typedef struct packed {
      logic        m;
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_t;

   ar_t ar_q[$];
   r_t  r_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc = 0;
   int  err_pulses = 0;
   int  last_err_cyc = -1;
   int  acc0 = 0;
   int  acc1 = 0;
   bit  in_burst = 1'b0;
   bit  owner = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
   endtask

   function automatic void push_ar(input bit m, input logic [3:0] id, input logic [31:0] addr,
                                   input logic [3:0] len);
      ar_q.push_back(ar_t'{{m, id}, addr, len, 3'd2, 2'd1});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic r_score(input bit m, input logic [3:0] id, input logic [31:0] data,
                          input logic [1:0] resp, input logic last);
      r_t e;
      if (r_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL r_unexpected: m%0d got data %h, expected no beat", m, data);
      end else begin
         e = r_q.pop_front();
         check("r_beat", 64'({m, id, data, resp, last}), 64'(e));
      end
   endtask

   // Monitor: scores every handshake the DUT presents and the R steering while a burst is live.
   always @(negedge clk) begin
      if (ARVALID_S && ARREADY_S) begin
         if (ar_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL ar_unexpected: got id %h addr %h, expected no request", ARID_S, ARADDR_S);
         end else begin
            check("ar_s", 64'({ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S}), 64'(ar_q.pop_front()));
         end
      end
      if (RVALID_M0 && RREADY_M0) r_score(1'b0, RID_M0, RDATA_M0, RRESP_M0, RLAST_M0);
      if (RVALID_M1 && RREADY_M1) r_score(1'b1, RID_M1, RDATA_M1, RRESP_M1, RLAST_M1);
      if (in_burst) begin
         check("rready_s", 64'(RREADY_S), 64'(owner ? RREADY_M1 : RREADY_M0));
         check("rvalid_owner", 64'(owner ? RVALID_M1 : RVALID_M0), 64'(RVALID_S));
         check("rvalid_other", 64'(owner ? RVALID_M0 : RVALID_M1), 64'(0));
      end
      if (ARREADY_M0 && ARREADY_M1) fail_now("arready_both");
      if (ARREADY_M0) acc0++;
      if (ARREADY_M1) acc1++;
      if (len_err) begin
         err_pulses++;
         last_err_cyc = cyc;
      end
   end

   task automatic check_rst(input string tag);
      check({tag, "_ctl"}, 64'({ARREADY_M0, ARREADY_M1, RVALID_M0, RVALID_M1, ARVALID_S, RREADY_S,
                                len_err, busy}), 64'(0));
      check({tag, "_ar_s"}, 64'({ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S}), 64'(0));
      check({tag, "_r_m0"}, 64'({RID_M0, RDATA_M0, RRESP_M0, RLAST_M0}), 64'(0));
      check({tag, "_r_m1"}, 64'({RID_M1, RDATA_M1, RRESP_M1, RLAST_M1}), 64'(0));
   endtask

   // Master: raise ARVALID with a payload, hold it until ARREADY, report the grant cycle.
   task automatic m_req(input bit m, input logic [3:0] id, input logic [31:0] addr,
                        input logic [3:0] len, output int gcyc);
      int n = 0;
      gcyc = -1;
      if (m) begin
         ARID_M1 = id; ARADDR_M1 = addr; ARLEN_M1 = len; ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'd1;
         ARVALID_M1 = 1'b1;
      end else begin
         ARID_M0 = id; ARADDR_M0 = addr; ARLEN_M0 = len; ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1;
         ARVALID_M0 = 1'b1;
      end
      @(negedge clk);
      while (!(m ? ARREADY_M1 : ARREADY_M0) && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (m ? ARREADY_M1 : ARREADY_M0) gcyc = cyc;
      else fail_now(m ? "m1_ar_wait" : "m0_ar_wait");
      tick();
      // Scramble the payload after acceptance so only the latched copy can be correct.
      if (m) begin
         ARVALID_M1 = 1'b0; ARID_M1 = 4'hF; ARADDR_M1 = 32'hFFFF_FFFF; ARLEN_M1 = 4'hF;
         ARSIZE_M1 = 3'd7; ARBURST_M1 = 2'd3;
      end else begin
         ARVALID_M0 = 1'b0; ARID_M0 = 4'hF; ARADDR_M0 = 32'hFFFF_FFFF; ARLEN_M0 = 4'hF;
         ARSIZE_M0 = 3'd7; ARBURST_M0 = 2'd3;
      end
   endtask

   // Slave: accept AR after ar_delay cycles, then return nbeats beats (RLAST on the last one).
   // Beat abort_at is never driven, leaving the burst open.
   task automatic slave_serve(input int ar_delay, input int nbeats, input bit m, input logic [3:0] id,
                              input logic [31:0] addr, input logic [3:0] len, input int abort_at,
                              output int av_cyc, output int first_cyc, output int last_cyc);
      int n = 0;
      int d = 0;
      logic [31:0] dat;
      av_cyc = -1; first_cyc = -1; last_cyc = -1;
      ARREADY_S = (ar_delay == 0);
      @(negedge clk);
      while (!ARVALID_S && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!ARVALID_S) begin
         fail_now("arvalid_s_wait");
         ARREADY_S = 1'b0;
         return;
      end
      av_cyc = cyc;
      while (!ARREADY_S) begin
         check("ar_hold", 64'({ARVALID_S, ARID_S, ARADDR_S, ARLEN_S}), 64'({1'b1, m, id, addr, len}));
         d++;
         tick();
         if (d >= ar_delay) ARREADY_S = 1'b1;
         @(negedge clk);
      end
      tick();
      ARREADY_S = 1'b0;
      owner = m;
      in_burst = 1'b1;
      for (int i = 0; i < nbeats; i++) begin
         if (i == abort_at) break;
         dat = addr + 32'(i * 32'h11);
         RVALID_S = 1'b1;
         RID_S = {m, id};
         RDATA_S = dat;
         RRESP_S = 2'(i);
         RLAST_S = (i == nbeats - 1);
         r_q.push_back(r_t'{m, id, dat, 2'(i), (i == nbeats - 1)});
         n = 0;
         @(negedge clk);
         while (!RREADY_S && n < 100) begin
            n++;
            tick();
            @(negedge clk);
         end
         if (!RREADY_S) fail_now("rready_s_wait");
         if (i == 0) first_cyc = cyc;
         if (i == nbeats - 1) last_cyc = cyc;
         tick();
      end
      RVALID_S = 1'b0;
      RLAST_S = 1'b0;
      in_burst = 1'b0;
   endtask

   initial begin
      int g0, g1, av, f, l, l1, rel;
      logic [15:0] pat;
      g0 = 0; g1 = 0; av = 0; f = 0; l = 0; l1 = 0; rel = 0;
      pat = 16'b1011_0010_1101_0110;
      rst = 1'b1;
      ARID_M0 = '0; ARADDR_M0 = '0; ARLEN_M0 = '0; ARSIZE_M0 = '0; ARBURST_M0 = '0; ARVALID_M0 = 1'b0;
      ARID_M1 = '0; ARADDR_M1 = '0; ARLEN_M1 = '0; ARSIZE_M1 = '0; ARBURST_M1 = '0; ARVALID_M1 = 1'b0;
      RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
      ARREADY_S = 1'b0; RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 1'b0; RVALID_S = 1'b0;

      // Power-on reset.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_rst("init");
      tick();
      rst = 1'b0;

      // Contention from reset, twice: expected grant order M0, M1, M0, M1.
      for (int k = 0; k < 2; k++) begin
         push_ar(1'b0, 4'(2 * k + 1), 32'h0000_1000 + 32'(k * 256), 4'd1);
         push_ar(1'b1, 4'(2 * k + 2), 32'h0000_2000 + 32'(k * 256), 4'd0);
         fork
            m_req(1'b0, 4'(2 * k + 1), 32'h0000_1000 + 32'(k * 256), 4'd1, g0);
            m_req(1'b1, 4'(2 * k + 2), 32'h0000_2000 + 32'(k * 256), 4'd0, g1);
            begin
               slave_serve(0, 2, 1'b0, 4'(2 * k + 1), 32'h0000_1000 + 32'(k * 256), 4'd1, -1, av, f, l);
               slave_serve(0, 1, 1'b1, 4'(2 * k + 2), 32'h0000_2000 + 32'(k * 256), 4'd0, -1, av, f, l);
            end
         join
         check("rr_m0_before_m1", 64'(g0 < g1), 64'(1));
      end
      check("arready_m0_cycles", 64'(acc0), 64'(2));
      check("arready_m1_cycles", 64'(acc1), 64'(2));

      // Single master M1: ARID_S = 0x15, ARVALID_S one cycle after grant, first beat two after.
      err_pulses = 0;
      push_ar(1'b1, 4'd5, 32'h0001_0000, 4'd3);
      fork
         m_req(1'b1, 4'd5, 32'h0001_0000, 4'd3, g1);
         slave_serve(0, 4, 1'b1, 4'd5, 32'h0001_0000, 4'd3, -1, av, f, l);
      join
      check("m1_arvalid_latency", 64'(av - g1), 64'(1));
      check("m1_first_beat_latency", 64'(f - g1), 64'(2));
      @(negedge clk);
      check("m1_busy_after_last", 64'(busy), 64'(0));
      check("m1_len_err_none", 64'(err_pulses), 64'(0));
      tick();

      // Backpressure: ARREADY_S low 3 cycles, RREADY_M0 toggling through a 4-beat burst.
      err_pulses = 0;
      push_ar(1'b0, 4'd7, 32'h0000_8000, 4'd3);
      fork
         m_req(1'b0, 4'd7, 32'h0000_8000, 4'd3, g0);
         slave_serve(3, 4, 1'b0, 4'd7, 32'h0000_8000, 4'd3, -1, av, f, l);
         begin
            for (int k = 0; k < 16; k++) begin
               RREADY_M0 = pat[k];
               tick();
            end
            RREADY_M0 = 1'b1;
         end
      join
      check("bp_arvalid_latency", 64'(av - g0), 64'(1));
      @(negedge clk);
      check("bp_len_err_none", 64'(err_pulses), 64'(0));
      tick();

      // Short burst: ARLEN=3 but RLAST on beat 2 -> one pulse, the cycle after the last beat.
      err_pulses = 0;
      push_ar(1'b0, 4'd2, 32'h0000_9000, 4'd3);
      fork
         m_req(1'b0, 4'd2, 32'h0000_9000, 4'd3, g0);
         slave_serve(0, 2, 1'b0, 4'd2, 32'h0000_9000, 4'd3, -1, av, f, l);
      join
      @(negedge clk);
      check("short_idle", 64'(busy), 64'(0));
      @(negedge clk);
      check("short_len_err_pulses", 64'(err_pulses), 64'(1));
      check("short_len_err_cycle", 64'(last_err_cyc - l), 64'(1));
      tick();

      // Long burst: ARLEN=1, RLAST on beat 3. Beat 2 sits at index ARLEN without RLAST, and
      // beat 3 carries RLAST at index 2 != ARLEN, so both beats raise a pulse.
      err_pulses = 0;
      push_ar(1'b0, 4'd4, 32'h0000_A000, 4'd1);
      fork
         m_req(1'b0, 4'd4, 32'h0000_A000, 4'd1, g0);
         slave_serve(0, 3, 1'b0, 4'd4, 32'h0000_A000, 4'd1, -1, av, f, l);
      join
      @(negedge clk);
      check("long_idle", 64'(busy), 64'(0));
      @(negedge clk);
      check("long_len_err_pulses", 64'(err_pulses), 64'(2));
      check("long_len_err_cycle", 64'(last_err_cyc - l), 64'(1));
      tick();

      // Full-length burst: ARLEN=15, 16 beats, counter reaches its top value cleanly.
      err_pulses = 0;
      push_ar(1'b1, 4'd6, 32'h0000_B000, 4'd15);
      fork
         m_req(1'b1, 4'd6, 32'h0000_B000, 4'd15, g1);
         slave_serve(0, 16, 1'b1, 4'd6, 32'h0000_B000, 4'd15, -1, av, f, l);
      join
      @(negedge clk);
      check("full_len_err_none", 64'(err_pulses), 64'(0));
      tick();

      // Back-to-back: M0 waits through M1's burst and is accepted the cycle after RLAST.
      push_ar(1'b1, 4'd9, 32'h0000_3000, 4'd3);
      push_ar(1'b0, 4'd10, 32'h0000_4000, 4'd0);
      fork
         m_req(1'b1, 4'd9, 32'h0000_3000, 4'd3, g1);
         begin
            repeat (3) tick();
            m_req(1'b0, 4'd10, 32'h0000_4000, 4'd0, g0);
         end
         begin
            slave_serve(0, 4, 1'b1, 4'd9, 32'h0000_3000, 4'd3, -1, av, f, l1);
            slave_serve(0, 1, 1'b0, 4'd10, 32'h0000_4000, 4'd0, -1, av, f, l);
         end
      join
      check("b2b_arready_m0", 64'(g0 - l1), 64'(1));

      // Reset for 2 cycles in the middle of an 8-beat burst (priority currently favours M1).
      err_pulses = 0;
      push_ar(1'b0, 4'd3, 32'h0000_5000, 4'd7);
      fork
         m_req(1'b0, 4'd3, 32'h0000_5000, 4'd7, g0);
         slave_serve(0, 8, 1'b0, 4'd3, 32'h0000_5000, 4'd7, 3, av, f, l);
      join
      rst = 1'b1;
      RREADY_M0 = 1'b0;
      RVALID_S = 1'b1; RID_S = 5'h03; RDATA_S = 32'hCAFE_F00D; RRESP_S = 2'b10; RLAST_S = 1'b1;
      tick();
      RREADY_M0 = 1'b1;
      @(negedge clk);
      check_rst("midrst1");
      tick();
      @(negedge clk);
      check_rst("midrst2");
      tick();
      rst = 1'b0;
      RVALID_S = 1'b0; RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 1'b0;
      rel = cyc;
      check("midrst_len_err_none", 64'(err_pulses), 64'(0));

      // Fresh simultaneous request after reset: M0 wins because priority was reset.
      push_ar(1'b0, 4'd1, 32'h0000_6000, 4'd3);
      push_ar(1'b1, 4'd2, 32'h0000_7000, 4'd0);
      fork
         m_req(1'b0, 4'd1, 32'h0000_6000, 4'd3, g0);
         m_req(1'b1, 4'd2, 32'h0000_7000, 4'd0, g1);
         begin
            slave_serve(0, 4, 1'b0, 4'd1, 32'h0000_6000, 4'd3, -1, av, f, l);
            slave_serve(0, 1, 1'b1, 4'd2, 32'h0000_7000, 4'd0, -1, av, f, l);
         end
      join
      check("post_rst_grant_cycle", 64'(g0 - rel), 64'(0));
      check("post_rst_m0_first", 64'(g0 < g1), 64'(1));

      repeat (2) tick();
      check("ar_queue_drained", 64'(ar_q.size()), 64'(0));
      check("r_queue_drained", 64'(r_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

endmodule
